bcd_e3_seq: RTL and testbench

- Sequencer that converts an N-digit packed BCD word to Excess-3 one digit per clock.
- Uses a single shared combinational 4-bit BCD-to-Excess-3 converter, instantiated outside this block.
- Presents one digit per cycle on conv_bcd, captures conv_e3 into the matching result slice, flags non-BCD digits, and signals completion with a one-cycle done pulse.
- Sits between a digit-word producer and the existing converter, so a wide conversion needs no replicated converters.

---
 rtl/bcd_e3_seq.sv | 134 +++++++++++++
 tb/tb_bcd_e3_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_e3_seq.sv
// Digit-serial packed-BCD to Excess-3 sequencer driving one shared external
// 4-bit converter; captures one result digit per clock and pulses done.
module bcd_e3_seq #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic [3:0]          conv_bcd,
  input  logic [3:0]          conv_e3,
  output logic [4*DIGITS-1:0] e3_out,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_n;
  logic [IW-1:0]       idx_r;
  logic [4*DIGITS-1:0] shadow_r;
  logic [4*DIGITS-1:0] e3_r;
  logic                err_r;
  logic [3:0]          digit_s;

  function automatic logic is_bad_bcd(input logic [3:0] d);
    return (d > 4'd9);
  endfunction

  assign digit_s = shadow_r[{idx_r, 2'b00} +: 4];
  assign e3_out  = e3_r;
  assign err     = err_r;

  // Next-state and converter/status outputs; abort squashes the done pulse.
  always_comb begin
    state_n  = state_r;
    conv_bcd = 4'd0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          state_n = CONV;
        end else begin
          state_n = IDLE;
        end
      end
      CONV: begin
        conv_bcd = digit_s;
        busy     = 1'b1;
        if (abort) begin
          state_n = IDLE;
        end else if (idx_r == LAST_IDX) begin
          state_n = DONE;
        end else begin
          state_n = CONV;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = !abort;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, shadow word, digit index and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      idx_r    <= '0;
      shadow_r <= '0;
      e3_r     <= '0;
      err_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      case (state_r)
        IDLE: begin
          if (start && !abort) begin
            shadow_r <= bcd_in;
            e3_r     <= '0;
            err_r    <= 1'b0;
            idx_r    <= '0;
          end
        end
        CONV: begin
          if (abort) begin
            e3_r  <= '0;
            err_r <= 1'b0;
            idx_r <= '0;
          end else begin
            // Converter output is only trusted for 0-9; flag others as 4'hF.
            for (int i = 0; i < DIGITS; i++) begin
              if (idx_r == IW'(i)) begin
                e3_r[4*i +: 4] <= is_bad_bcd(digit_s) ? 4'hF : conv_e3;
              end
            end
            if (is_bad_bcd(digit_s)) begin
              err_r <= 1'b1;
            end
            if (idx_r == LAST_IDX) begin
              idx_r <= '0;
            end else begin
              idx_r <= idx_r + IW'(1);
            end
          end
        end
        DONE: begin
          if (abort) begin
            e3_r  <= '0;
            err_r <= 1'b0;
          end
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_e3_seq.sv
// Bench for bcd_e3_seq: job-level reference model checked every cycle,
// directed jobs pinned with literal results, then randomized traffic.
module tb_bcd_e3_seq;

  localparam int DIGITS = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                abort;
  logic [4*DIGITS-1:0] bcd_in;
  logic [3:0]          conv_bcd;
  logic [3:0]          conv_e3;
  logic [4*DIGITS-1:0] e3_out;
  logic                busy;
  logic                done;
  logic                err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Job-level model: accepted word and how many digits have been produced.
  bit                  m_act = 1'b0;
  int                  m_cnt = 0;
  logic [4*DIGITS-1:0] m_job = '0;

  bcd_e3_seq #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bcd_in(bcd_in),
    .conv_bcd(conv_bcd), .conv_e3(conv_e3), .e3_out(e3_out),
    .busy(busy), .done(done), .err(err)
  );

  // External converter stand-in: plain +3 on the presented digit.
  assign conv_e3 = conv_bcd + 4'd3;

  always #5 clk = ~clk;

  function automatic logic [4*DIGITS-1:0] reveal(input logic [4*DIGITS-1:0] w, input int cnt);
    logic [4*DIGITS-1:0] r;
    logic [3:0] d;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = w[4*i +: 4];
      if (i < cnt) r[4*i +: 4] = (d > 4'd9) ? 4'hF : d + 4'd3;
    end
    return r;
  endfunction

  function automatic logic any_bad(input logic [4*DIGITS-1:0] w, input int cnt);
    logic b;
    b = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (i < cnt && w[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act <= 1'b0;
      m_cnt <= 0;
      m_job <= '0;
    end else if (!m_act) begin
      if (start && !abort) begin
        m_act <= 1'b1;
        m_cnt <= 0;
        m_job <= bcd_in;
      end
    end else if (abort) begin
      m_act <= 1'b0;
      m_cnt <= 0;
      m_job <= '0;
    end else if (m_cnt == DIGITS) begin
      m_act <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_act));
      check("done", 32'(done), 32'(m_act && m_cnt == DIGITS && !abort));
      check("conv_bcd", 32'(conv_bcd),
            (m_act && m_cnt < DIGITS) ? 32'(m_job[4*m_cnt +: 4]) : 32'd0);
      check("e3_out", 32'(e3_out), 32'(reveal(m_job, m_cnt)));
      check("err", 32'(err), 32'(any_bad(m_job, m_cnt)));
    end
  end

  // Call at posedge+1 of the first cycle after acceptance; returns at done's negedge.
  task automatic wait_done(input int budget, output int cyc, output bit seen);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= budget) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
  endtask

  task automatic run_job(input logic [15:0] w, input logic [15:0] exp, input logic exp_err);
    int cyc;
    bit seen;
    @(posedge clk); #1;
    bcd_in = w;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    bcd_in = 16'($urandom);
    wait_done(20, cyc, seen);
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'd5);
    check("job_e3", 32'(e3_out), 32'(exp));
    check("job_err", 32'(err), 32'(exp_err));
  endtask

  task automatic cancel_check(input string name);
    int ndone;
    @(negedge clk);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_e3"}, 32'(e3_out), 32'd0);
    check({name, "_err"}, 32'(err), 32'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check({name, "_nodone"}, 32'(ndone), 32'd0);
  endtask

  initial begin
    int cyc;
    bit seen;
    logic [15:0] w;
    rst_n  = 1'b0;
    start  = 1'b1;
    abort  = 1'b0;
    bcd_in = 16'h1234;

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_e3", 32'(e3_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_conv", 32'(conv_bcd), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("rst_nojob", 32'(busy), 32'd0);

    run_job(16'h1234, 16'h4567, 1'b0);
    run_job(16'h9990, 16'hCCC3, 1'b0);
    run_job(16'h0000, 16'h3333, 1'b0);
    run_job(16'h12A4, 16'h45F7, 1'b1);
    run_job(16'h0001, 16'h3334, 1'b0);

    // Start held and bcd_in changed while busy: second job only from IDLE.
    @(posedge clk); #1;
    bcd_in = 16'h1234;
    start  = 1'b1;
    @(posedge clk); #1;
    bcd_in = 16'h9999;
    wait_done(20, cyc, seen);
    check("busy1_seen", 32'(seen), 32'd1);
    check("busy1_e3", 32'(e3_out), 32'h4567);
    @(posedge clk); #1;
    wait_done(20, cyc, seen);
    check("busy2_seen", 32'(seen), 32'd1);
    check("busy2_e3", 32'(e3_out), 32'hCCCC);
    @(posedge clk); #1;
    start = 1'b0;

    // Abort during the second CONV cycle.
    @(posedge clk); #1;
    bcd_in = 16'h1234;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    cancel_check("abort");

    // Reset during the second CONV cycle.
    @(posedge clk); #1;
    bcd_in = 16'h1234;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cancel_check("midrst");
    run_job(16'h5678, 16'h89AB, 1'b0);

    // Randomized traffic, mostly valid digits, occasional abort/reset.
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < DIGITS; i++)
        w[4*i +: 4] = ($urandom_range(0, 15) < 13) ? 4'($urandom_range(0, 9))
                                                   : 4'($urandom_range(10, 15));
      bcd_in = w;
      start  = ($urandom_range(0, 9) < 4);
      abort  = ($urandom_range(0, 99) < 6);
      rst_n  = !($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
